icache_responder: RTL

- Direct-mapped instruction cache on the responder side of the datapath instruction-fetch interface.
- Accepts imemREN/imemaddr from the pipeline's fetch stage and returns ihit/imemload.
- On a miss it fetches one word from the memory controller over a iREN/iaddr/iwait/iload handshake, fills the frame, then serves the request as a hit.
- Sits between the datapath and the memory controller, inside the cache wrapper.

---
 rtl/icache_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module icache_responder #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        invalidate,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = 30 - IDX;

   typedef enum logic {
      IDLE,
      FETCH
   } state_t;

   state_t state, next_state;

   logic [SETS-1:0] valid;
   logic [TAGW-1:0] tags  [SETS];
   logic [31:0]     words [SETS];

   logic [29:0]     miss_word;
   logic [IDX-1:0]  req_idx;
   logic [IDX-1:0]  fill_idx;
   logic [TAGW-1:0] req_tag;
   logic            lookup_hit;
   logic            start_miss;
   logic            fill;
   logic            unused_addr_bits;

   assign req_idx          = imemaddr[IDX+1:2];
   assign req_tag          = imemaddr[31:IDX+2];
   assign fill_idx         = miss_word[IDX-1:0];
   assign lookup_hit       = valid[req_idx] && (tags[req_idx] == req_tag);
   assign iaddr            = {miss_word, 2'b00};
   assign unused_addr_bits = ^imemaddr[1:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Hits are answered combinationally in IDLE; FETCH blocks every request until the fill word arrives.
   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      imemload   = 32'h0;
      iREN       = 1'b0;
      start_miss = 1'b0;
      fill       = 1'b0;
      case (state)
         IDLE: begin
            if (imemREN) begin
               if (lookup_hit) begin
                  ihit     = 1'b1;
                  imemload = words[req_idx];
               end else begin
                  start_miss = 1'b1;
                  next_state = FETCH;
               end
            end
         end
         FETCH: begin
            iREN = 1'b1;
            if (!iwait) begin
               fill       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The fill's valid-bit set comes after the invalidate clear, so the frame being filled survives.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid     <= '0;
         miss_word <= '0;
      end else begin
         if (start_miss) begin
            miss_word <= imemaddr[31:2];
         end
         if (invalidate) begin
            valid <= '0;
         end
         if (fill) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (fill && !RST) begin
         tags[fill_idx]  <= miss_word[29:IDX];
         words[fill_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (start_miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule
